// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan driver.
package hub75_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    function automatic int unsigned col_width(int unsigned width);
        return $clog2(width);
    endfunction

    function automatic int unsigned row_width(int unsigned height);
        return $clog2(height / 2);
    endfunction

    function automatic int unsigned plane_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned shift_width(int unsigned width);
        return $clog2(2 * width + 2);
    endfunction

    // Wide enough to hold the longest plane's on-time, BASE_OE << (depth-1).
    function automatic int unsigned oe_width(int unsigned base_oe, int unsigned depth);
        return $clog2((base_oe << (depth - 1)) + 1);
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// DISPLAY on-time counter for one bitplane; loads on start, flags done at zero.
// HUB75_BRIGHTNESS_EN enables brightness scaling of the on-time.
module hub75_oe_timer import hub75_pkg::*; #(
    parameter int unsigned COLOR_DEPTH = 7,
    parameter int unsigned BASE_OE     = 8,
    localparam int unsigned PW         = plane_width(COLOR_DEPTH)
) (
    input  logic          display_clock,
    input  logic          display_rst_n,
    input  logic          start,
    input  logic [PW-1:0] plane,
    input  logic [7:0]    brightness,
    output logic          done
);

    localparam int unsigned OW = oe_width(BASE_OE, COLOR_DEPTH);

    logic [OW-1:0] base_time;
    logic [OW-1:0] on_time;
    logic [OW-1:0] count;

    assign base_time = OW'(BASE_OE) << plane;

`ifdef HUB75_BRIGHTNESS_EN
    logic [OW+8:0] scaled;
    assign scaled  = ({9'd0, base_time} * {{OW{1'b0}}, {1'b0, brightness} + 9'd1}) >> 8;
    // Never let a plane go fully dark, even at brightness 0.
    assign on_time = (scaled == '0) ? OW'(1) : scaled[OW-1:0];
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign on_time           = base_time;
`endif

    always_ff @(posedge display_clock or negedge display_rst_n) begin
        if (!display_rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= on_time - OW'(1);
        end else if (count != '0) begin
            count <= count - OW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver: per-row bitplane shift, blank, latch and BCM display.
// Define HUB75_BRIGHTNESS_EN to scale on-time by the brightness input.
module hub75_scan_driver import hub75_pkg::*; #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned COLOR_DEPTH = 7,
    parameter int unsigned BASE_OE     = 8,
    localparam int unsigned CW         = col_width(WIDTH),
    localparam int unsigned RW         = row_width(HEIGHT)
) (
    input  logic                     display_clock,
    input  logic                     display_rst_n,
    input  logic                     enable,
    input  logic [7:0]               brightness,
    output logic [CW-1:0]            pix_x,
    output logic [RW-1:0]            pix_y,
    input  logic [3*COLOR_DEPTH-1:0] pix_rgb0,
    input  logic [3*COLOR_DEPTH-1:0] pix_rgb1,
    output logic [2:0]               panel_rgb0,
    output logic [2:0]               panel_rgb1,
    output logic [RW-1:0]            panel_addr,
    output logic                     panel_clk,
    output logic                     panel_stb,
    output logic                     panel_oe,
    output logic                     frame_done
);

    localparam int unsigned PW         = plane_width(COLOR_DEPTH);
    localparam int unsigned SW         = shift_width(WIDTH);
    localparam int unsigned SHIFT_LAST = 2 * WIDTH + 1;
    localparam int unsigned CD         = COLOR_DEPTH;

    state_e           state;
    logic [SW-1:0]    shift_cnt;
    logic [PW-1:0]    plane;
    logic [CD-1:0]    plane_mask;
    logic [2:0]       bits0;
    logic [2:0]       bits1;
    logic             timer_start;
    logic             timer_done;

    assign plane_mask  = CD'(1) << plane;
    assign bits0       = {|(pix_rgb0[3*CD-1:2*CD] & plane_mask),
                          |(pix_rgb0[2*CD-1:CD] & plane_mask),
                          |(pix_rgb0[CD-1:0] & plane_mask)};
    assign bits1       = {|(pix_rgb1[3*CD-1:2*CD] & plane_mask),
                          |(pix_rgb1[2*CD-1:CD] & plane_mask),
                          |(pix_rgb1[CD-1:0] & plane_mask)};
    assign timer_start = (state == StLatch);

    hub75_oe_timer #(
        .COLOR_DEPTH(COLOR_DEPTH),
        .BASE_OE    (BASE_OE)
    ) u_oe_timer (
        .display_clock(display_clock),
        .display_rst_n(display_rst_n),
        .start        (timer_start),
        .plane        (plane),
        .brightness   (brightness),
        .done         (timer_done)
    );

    always_ff @(posedge display_clock or negedge display_rst_n) begin
        if (!display_rst_n) begin
            state      <= StIdle;
            shift_cnt  <= '0;
            plane      <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            panel_rgb0 <= '0;
            panel_rgb1 <= '0;
            panel_addr <= '0;
            panel_clk  <= 1'b0;
            panel_stb  <= 1'b0;
            panel_oe   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            panel_clk  <= 1'b0;
            panel_stb  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    panel_oe <= 1'b1;
                    if (enable) begin
                        state     <= StShift;
                        shift_cnt <= '0;
                        pix_x     <= '0;
                    end
                end
                StShift: begin
                    shift_cnt <= shift_cnt + SW'(1);
                    // Odd cycles: pixel for pix_x has returned; capture it and fetch the next.
                    if (shift_cnt[0]) begin
                        panel_rgb0 <= bits0;
                        panel_rgb1 <= bits1;
                        if (pix_x != CW'(WIDTH - 1)) begin
                            pix_x <= pix_x + CW'(1);
                        end
                    end else if (shift_cnt != '0) begin
                        panel_clk <= 1'b1;
                    end
                    if (shift_cnt == SW'(SHIFT_LAST)) begin
                        state      <= StBlank;
                        shift_cnt  <= '0;
                        panel_rgb0 <= '0;
                        panel_rgb1 <= '0;
                        panel_addr <= pix_y;
                    end
                end
                StBlank: begin
                    if (shift_cnt == SW'(1)) begin
                        state     <= StLatch;
                        shift_cnt <= '0;
                        panel_stb <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + SW'(1);
                    end
                end
                StLatch: begin
                    state    <= StDisplay;
                    panel_oe <= 1'b0;
                end
                StDisplay: begin
                    if (timer_done) begin
                        panel_oe  <= 1'b1;
                        pix_x     <= '0;
                        shift_cnt <= '0;
                        state     <= StShift;
                        if (plane != PW'(COLOR_DEPTH - 1)) begin
                            plane <= plane + PW'(1);
                        end else begin
                            plane <= '0;
                            if (pix_y != RW'(HEIGHT / 2 - 1)) begin
                                pix_y <= pix_y + RW'(1);
                            end else begin
                                pix_y      <= '0;
                                frame_done <= 1'b1;
                                if (!enable) begin
                                    state <= StIdle;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    panel_oe <= 1'b1;
                end
            endcase
        end
    end

endmodule
